// File: rtl/mult3_rr_scheduler.sv
// Round-robin front end that shares one three-input multiplier among NUM_REQ
// requesters: it arbitrates, runs the multiplier handshake and returns the product.
module mult3_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RES_W   = 128
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ*DATA_W-1:0] iData_A,
    input  logic [NUM_REQ*DATA_W-1:0] iData_B,
    input  logic [NUM_REQ*DATA_W-1:0] iData_C,
    input  logic [NUM_REQ-1:0]        iReqAck,
    output logic [NUM_REQ-1:0]        oGrant,
    output logic [NUM_REQ-1:0]        oReqDone,
    output logic [RES_W-1:0]          oResult,
    output logic                      oBusy,
    output logic [DATA_W-1:0]         oMul_A,
    output logic [DATA_W-1:0]         oMul_B,
    output logic [DATA_W-1:0]         oMul_C,
    output logic                      oMul_Valid,
    output logic                      oMul_Ack,
    input  logic                      iMul_Done,
    input  logic                      iMul_Idle,
    input  logic [RES_W-1:0]          iMul_Result
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_MACK, S_RET, S_REL
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, win_q, win_d, arb_idx;
    logic                 arb_found;
    logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
    logic [RES_W-1:0]     result_q, result_d;
    logic [DATA_W-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_c_q, mul_c_d;
    logic                 valid_q, valid_d, ack_q, ack_d, busy_q, busy_d;

    // First set request at or above the pointer, wrapping at NUM_REQ.
    always_comb begin : arbiter
        int unsigned p;
        p         = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            p = 32'(ptr_q) + k;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (!arb_found && iReq[IDX_W'(p)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(p);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        grant_d  = grant_q;
        done_d   = done_q;
        result_d = result_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        mul_c_d  = mul_c_q;
        valid_d  = valid_q;
        ack_d    = ack_q;
        unique case (state_q)
            S_IDLE: if (arb_found && iMul_Idle) begin
                win_d            = arb_idx;
                grant_d          = '0;
                grant_d[arb_idx] = 1'b1;
                mul_a_d          = iData_A[32'(arb_idx)*DATA_W +: DATA_W];
                mul_b_d          = iData_B[32'(arb_idx)*DATA_W +: DATA_W];
                mul_c_d          = iData_C[32'(arb_idx)*DATA_W +: DATA_W];
                valid_d          = 1'b1;
                state_d          = S_LAUNCH;
            end
            // A multiplier that finishes before dropping Idle skips S_WAIT entirely.
            S_LAUNCH: if (iMul_Done) begin
                result_d = iMul_Result;
                ack_d    = 1'b1;
                valid_d  = 1'b0;
                state_d  = S_MACK;
            end else if (!iMul_Idle) begin
                valid_d  = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: if (iMul_Done) begin
                result_d = iMul_Result;
                ack_d    = 1'b1;
                state_d  = S_MACK;
            end
            S_MACK: if (!iMul_Done) begin
                ack_d         = 1'b0;
                done_d        = '0;
                done_d[win_q] = 1'b1;
                state_d       = S_RET;
            end
            S_RET: if (iReqAck[win_q]) begin
                done_d  = '0;
                state_d = S_REL;
            end
            S_REL: if (!iReqAck[win_q]) begin
                grant_d = '0;
                ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_c_q  <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            mul_c_q  <= mul_c_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign oGrant     = grant_q;
    assign oReqDone   = done_q;
    assign oResult    = result_q;
    assign oBusy      = busy_q;
    assign oMul_A     = mul_a_q;
    assign oMul_B     = mul_b_q;
    assign oMul_C     = mul_c_q;
    assign oMul_Valid = valid_q;
    assign oMul_Ack   = ack_q;

endmodule

// File: tb/tb_mult3_rr_scheduler.sv
// Directed bench for mult3_rr_scheduler with a behavioural multiplier that
// raises Done 8 cycles after accepting Valid and holds it until acknowledged.
module tb_mult3_rr_scheduler;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 128;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [N-1:0]  iReq = '0, iReqAck = '0;
    logic [N*DW-1:0] iData_A = '0, iData_B = '0, iData_C = '0;
    logic [N-1:0]  oGrant, oReqDone;
    logic [RW-1:0] oResult;
    logic          oBusy, oMul_Valid, oMul_Ack;
    logic [DW-1:0] oMul_A, oMul_B, oMul_C;
    logic          iMul_Done, iMul_Idle;
    logic [RW-1:0] iMul_Result;

    int npass = 0;
    int ntotal = 0;
    logic hold_busy = 1'b0;
    logic ack_seen = 1'b0;
    logic overlap = 1'b0;
    logic seen_bad = 1'b0;
    int   cyc;

    mult3_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .RES_W(RW)) dut (
        .Clock(Clock), .Reset(Reset), .iReq(iReq),
        .iData_A(iData_A), .iData_B(iData_B), .iData_C(iData_C),
        .iReqAck(iReqAck), .oGrant(oGrant), .oReqDone(oReqDone),
        .oResult(oResult), .oBusy(oBusy),
        .oMul_A(oMul_A), .oMul_B(oMul_B), .oMul_C(oMul_C),
        .oMul_Valid(oMul_Valid), .oMul_Ack(oMul_Ack),
        .iMul_Done(iMul_Done), .iMul_Idle(iMul_Idle), .iMul_Result(iMul_Result)
    );

    always #5 Clock = ~Clock;

    logic          m_busy, m_done;
    int            m_cnt;
    logic [RW-1:0] m_prod, m_res;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_prod <= '0; m_res <= '0;
        end else if (m_done) begin
            if (oMul_Ack) begin m_done <= 1'b0; m_busy <= 1'b0; end
        end else if (m_busy) begin
            if (m_cnt == 1) begin m_done <= 1'b1; m_res <= m_prod; end
            else m_cnt <= m_cnt - 1;
        end else if (oMul_Valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 8;
            m_prod <= RW'(oMul_A) * RW'(oMul_B) * RW'(oMul_C);
        end
    end

    assign iMul_Idle   = !m_busy && !hold_busy;
    assign iMul_Done   = m_done;
    assign iMul_Result = m_res;

    always @(negedge Clock) begin
        if (oMul_Ack) ack_seen = 1'b1;
        if ($countones(oGrant) > 1) overlap = 1'b1;
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return oGrant != '0;
            1: return oReqDone != '0;
            2: return oReqDone == '0;
            default: return oGrant == '0;
        endcase
    endfunction

    task automatic wait_cond(input int which, input string tag);
        int n = 0;
        while (!cond(which) && n < 60) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_wait"}, RW'(cond(which)), RW'(1));
    endtask

    task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c);
        iData_A[i*DW +: DW] = a;
        iData_B[i*DW +: DW] = b;
        iData_C[i*DW +: DW] = c;
    endtask

    task automatic finish_ret(input int i, input string tag);
        iReq[i]    = 1'b0;
        iReqAck[i] = 1'b1;
        wait_cond(2, {tag, "_done_clr"});
        iReqAck[i] = 1'b0;
        wait_cond(3, {tag, "_grant_clr"});
    endtask

    task automatic do_txn(input int i, input logic [RW-1:0] exp_res, input string tag);
        wait_cond(0, {tag, "_grant"});
        check({tag, "_grant"}, RW'(oGrant), RW'(4'b0001 << i));
        wait_cond(1, {tag, "_done"});
        check({tag, "_reqdone"}, RW'(oReqDone), RW'(4'b0001 << i));
        check({tag, "_result"}, oResult, exp_res);
        finish_ret(i, tag);
    endtask

    initial begin
        #1;
        check("rst_grant", RW'(oGrant), '0);
        check("rst_valid", RW'(oMul_Valid), '0);
        check("rst_busy", RW'(oBusy), '0);
        check("rst_result", oResult, '0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        // a pulse that never reaches a sampling edge is not served
        iReq[1] = 1'b1;
        #2 iReq[1] = 1'b0;
        repeat (3) @(negedge Clock);
        check("pulse_nogrant", RW'(oGrant), '0);
        check("pulse_nobusy", RW'(oBusy), '0);

        set_ops(2, 1, 2, 3);
        ack_seen = 1'b0;
        iReq[2]  = 1'b1;
        wait_cond(0, "t1");
        check("t1_grant", RW'(oGrant), RW'(4'b0100));
        check("t1_valid", RW'(oMul_Valid), RW'(1));
        check("t1_op_a", RW'(oMul_A), RW'(1));
        check("t1_op_b", RW'(oMul_B), RW'(2));
        check("t1_op_c", RW'(oMul_C), RW'(3));
        wait_cond(1, "t1");
        check("t1_reqdone", RW'(oReqDone), RW'(4'b0100));
        check("t1_result", oResult, RW'(6));
        check("t1_ack_pulse", RW'(ack_seen), RW'(1));
        check("t1_ack_low", RW'(oMul_Ack), '0);
        finish_ret(2, "t1");

        // pointer now 3: requester 3 wins over 0
        set_ops(0, 1, 2, 3);
        set_ops(3, 4, 5, 6);
        iReq = 4'b1001;
        do_txn(3, RW'(120), "ptr3");
        do_txn(0, RW'(6), "ptr0");

        set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        iReq = 4'b0010;
        do_txn(1, 128'h0000_0000_FFFF_FFFD_0000_0002_FFFF_FFFF, "max");
        check("max_hi_zero", RW'(oResult[127:96]), '0);

        set_ops(2, 3, 4, 5);
        iReq = 4'b0100;
        wait_cond(0, "rstmid");
        repeat (4) @(negedge Clock);
        check("rstmid_inwait_busy", RW'(oBusy), RW'(1));
        check("rstmid_inwait_valid", RW'(oMul_Valid), '0);
        #2 Reset = 1'b0;
        #1;
        check("rstmid_grant", RW'(oGrant), '0);
        check("rstmid_busy", RW'(oBusy), '0);
        check("rstmid_result", oResult, '0);
        check("rstmid_op_a", RW'(oMul_A), '0);
        iReq = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        for (int i = 0; i < 4; i++) set_ops(i, DW'(i + 1), DW'(i + 2), DW'(i + 3));
        overlap = 1'b0;
        iReq = 4'b1111;
        do_txn(0, RW'(6), "all0");
        do_txn(1, RW'(24), "all1");
        do_txn(2, RW'(60), "all2");
        do_txn(3, RW'(120), "all3");
        check("all_no_overlap", RW'(overlap), '0);

        iReq = 4'b1010;
        wait_cond(0, "drop");
        check("drop_grant", RW'(oGrant), RW'(4'b0010));
        @(negedge Clock);
        iReq[1] = 1'b0;
        wait_cond(1, "drop");
        check("drop_reqdone", RW'(oReqDone), RW'(4'b0010));
        check("drop_result", oResult, RW'(24));
        finish_ret(1, "drop");
        do_txn(3, RW'(120), "drop_next");

        hold_busy = 1'b1;
        iReq[3]   = 1'b1;
        seen_bad  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (oGrant != '0 || oMul_Valid) seen_bad = 1'b1;
        end
        check("notidle_held_off", RW'(seen_bad), '0);
        hold_busy = 1'b0;
        @(negedge Clock);
        check("notidle_grant_1cyc", RW'(oGrant), RW'(4'b1000));
        wait_cond(1, "notidle");
        iReqAck[0] = 1'b1;
        repeat (2) @(negedge Clock);
        check("wrongack_ignored", RW'(oReqDone), RW'(4'b1000));
        iReqAck[0] = 1'b0;
        check("notidle_result", oResult, RW'(120));
        finish_ret(3, "notidle");
        check("final_idle", RW'(oBusy), '0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
